// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the 3-sample voter.
// Intended to be reused by the companion transmitter.
package uart_rx_cfg_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Wide enough for up to 9 data bits or 2 stop bits
  localparam int BCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRKWAIT
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line in, decoded frame and status out.
// master = the receiver, slave = the line driver / frame consumer.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rx;
  logic [DATA_BITS-1:0] po_data;
  logic                 po_flag;
  logic                 po_perr;
  logic                 po_ferr;
  logic                 po_brk;

  modport master (input rx, output po_data, po_flag, po_perr, po_ferr, po_brk);
  modport slave  (output rx, input po_data, po_flag, po_perr, po_ferr, po_brk);
endinterface

// File: rtl/uart_rx_cfg_sync.sv
// Two-flop synchroniser for the asynchronous RX pin plus one delay flop for
// falling-edge detection. All flops reset to the idle-line level.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);
  logic r_ff1, r_ff2, r_dly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff1 <= 1'b1;
      r_ff2 <= 1'b1;
      r_dly <= 1'b1;
    end else begin
      r_ff1 <= i_rx;
      r_ff2 <= r_ff1;
      r_dly <= r_ff2;
    end
  end

  assign o_rx_s = r_ff2;
  assign o_fall = r_dly & ~r_ff2;
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: width/parity/stop bits, 3-sample majority vote,
// start-bit validation, parity/framing/break reporting.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          sclk,
  input  logic          rst_n,
  uart_rx_cfg_if.master io_bus
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int H     = CLK_DIV / 2;
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  C_HM1  = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0]  C_H    = CNT_W'(H);
  localparam logic [CNT_W-1:0]  C_HP1  = CNT_W'(H + 1);
  localparam logic [BCNT_W-1:0] B_DLAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] B_SLAST = BCNT_W'(STOP_BITS - 1);

  logic w_rx_s, w_fall, w_vote, w_at_vote, w_wrap;
  rx_state_t r_state, w_state_nx;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
  logic [BCNT_W-1:0]    r_bcnt, w_bcnt_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx, r_data, w_data_nx;
  logic r_s0, r_s1, r_pbit, w_pbit_nx, r_allz, w_allz_nx, r_stop0, w_stop0_nx;
  logic r_flag, w_flag_nx, r_perr, w_perr_nx, r_ferr, w_ferr_nx, r_brk, w_brk_nx;

  uart_rx_sync u_sync (
    .i_clk  (sclk),
    .i_rst_n(rst_n),
    .i_rx   (io_bus.rx),
    .o_rx_s (w_rx_s),
    .o_fall (w_fall)
  );

  assign w_vote    = maj3(r_s0, r_s1, w_rx_s);
  assign w_at_vote = (r_cnt == C_HP1);
  assign w_wrap    = (r_cnt == C_LAST);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_allz  <= 1'b0;
      r_stop0 <= 1'b0;
      r_data  <= '0;
      r_flag  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bcnt  <= w_bcnt_nx;
      r_allz  <= w_allz_nx;
      r_stop0 <= w_stop0_nx;
      r_data  <= w_data_nx;
      r_flag  <= w_flag_nx;
      r_perr  <= w_perr_nx;
      r_ferr  <= w_ferr_nx;
      r_brk   <= w_brk_nx;
    end
  end

  // Datapath: shift register, parity bit and the two early vote samples
  always_ff @(posedge sclk) begin
    r_shift <= w_shift_nx;
    r_pbit  <= w_pbit_nx;
    if (r_cnt == C_HM1) r_s0 <= w_rx_s;
    if (r_cnt == C_H)   r_s1 <= w_rx_s;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = w_wrap ? '0 : r_cnt + CNT_W'(1);
    w_bcnt_nx  = r_bcnt;
    w_shift_nx = r_shift;
    w_pbit_nx  = r_pbit;
    w_allz_nx  = r_allz;
    w_stop0_nx = r_stop0;
    w_data_nx  = r_data;
    w_flag_nx  = 1'b0;
    w_perr_nx  = r_perr;
    w_ferr_nx  = r_ferr;
    w_brk_nx   = r_brk;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        // The cycle in which the edge is seen is bit-cycle 0 of the start bit
        if (w_fall) begin
          w_state_nx = ST_START;
          w_cnt_nx   = CNT_W'(1);
          w_bcnt_nx  = '0;
          w_allz_nx  = 1'b1;
          w_stop0_nx = 1'b0;
        end
      end
      ST_START: begin
        if (w_at_vote && w_vote) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else if (w_wrap) begin
          w_state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_at_vote) begin
          w_shift_nx = {w_vote, r_shift[DATA_BITS-1:1]};
          w_allz_nx  = r_allz & ~w_vote;
        end
        if (w_wrap) begin
          if (r_bcnt == B_DLAST) begin
            w_bcnt_nx  = '0;
            w_state_nx = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            w_bcnt_nx = r_bcnt + BCNT_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (w_at_vote) begin
          w_pbit_nx = w_vote;
          w_allz_nx = r_allz & ~w_vote;
        end
        if (w_wrap) w_state_nx = ST_STOP;
      end
      ST_STOP: begin
        if (w_at_vote) begin
          w_stop0_nx = r_stop0 | ~w_vote;
          w_allz_nx  = r_allz & ~w_vote;
          // Last stop bit: publish the frame now rather than after the full bit
          if (r_bcnt == B_SLAST) begin
            w_flag_nx  = 1'b1;
            w_data_nx  = r_shift;
            w_perr_nx  = (PARITY == PAR_NONE) ? 1'b0
                         : ((^r_shift ^ r_pbit) != (PARITY == PAR_ODD));
            w_ferr_nx  = w_stop0_nx;
            w_brk_nx   = w_allz_nx;
            w_state_nx = w_allz_nx ? ST_BRKWAIT : ST_IDLE;
            w_cnt_nx   = '0;
          end
        end else if (w_wrap) begin
          w_bcnt_nx = r_bcnt + BCNT_W'(1);
        end
      end
      ST_BRKWAIT: begin
        w_cnt_nx = '0;
        if (w_rx_s) w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign io_bus.po_data = r_data;
  assign io_bus.po_flag = r_flag;
  assign io_bus.po_perr = r_perr;
  assign io_bus.po_ferr = r_ferr;
  assign io_bus.po_brk  = r_brk;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance at CLK_DIV=16,
// directed and randomised frames checked against a field-level frame model.
module tb_uart_rx_cfg;
  localparam int CLK_DIV = 16;

  logic sclk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  uart_rx_cfg_if #(.DATA_BITS(8)) if8 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if7 ();

  uart_rx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut8 (
    .sclk(sclk), .rst_n(rst_n), .io_bus(if8));
  uart_rx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut7 (
    .sclk(sclk), .rst_n(rst_n), .io_bus(if7));

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc = cyc + 1;

  // Frame capture on the falling edge, away from the active edge
  int n8 = 0, n7 = 0, t8 = 0, t7 = 0;
  logic [8:0] d8 = '0, d7 = '0;
  logic p8 = 0, f8 = 0, b8 = 0, p7 = 0, f7 = 0, b7 = 0;
  always @(negedge sclk) begin
    if (if8.po_flag === 1'b1) begin
      n8++; t8 = cyc; d8 = {1'b0, if8.po_data};
      p8 = if8.po_perr; f8 = if8.po_ferr; b8 = if8.po_brk;
    end
    if (if7.po_flag === 1'b1) begin
      n7++; t7 = cyc; d7 = {2'b00, if7.po_data};
      p7 = if7.po_perr; f7 = if7.po_ferr; b7 = if7.po_brk;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) if7.rx = v;
    else     if8.rx = v;
  endtask

  // Parity bit as the transmitter would send it (optionally corrupted)
  function automatic logic pbit_of(input logic [8:0] pay, input int par, input bit flip);
    logic even_ones;
    even_ones = ($countones(pay) % 2) == 0;
    if (par == 0) return 1'b1;
    return ((par == 1) ? even_ones : ~even_ones) ^ flip;
  endfunction

  // Line levels of a whole frame, index 0 = start bit
  function automatic logic [15:0] build(input logic [8:0] pay, input int db, input int par,
                                        input bit flip, input logic [1:0] stops, input int sb);
    logic [15:0] f;
    int k;
    f = '1; k = 1;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin f[k] = pay[i]; k++; end
    if (par != 0) begin f[k] = pbit_of(pay, par, flip); k++; end
    for (int i = 0; i < sb; i++) begin f[k] = stops[i]; k++; end
    return f;
  endfunction

  // Drive a frame with bit period per/100 sclk; cut>0 stops after cut cycles
  task automatic send(input bit sel, input logic [8:0] pay, input bit flip, input logic [1:0] stops,
                      input int per, input bit glitch, input int cut, output int t0);
    int db, par, sb, nb, total, b;
    logic [15:0] f;
    logic lvl;
    db = sel ? 7 : 8; par = sel ? 2 : 0; sb = sel ? 2 : 1;
    f = build(pay, db, par, flip, stops, sb);
    nb = 1 + db + ((par != 0) ? 1 : 0) + sb;
    total = (cut > 0) ? cut : (nb * per + 99) / 100;
    t0 = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge sclk);
      if (c == 0) t0 = cyc + 1;
      b = (c * 100) / per;
      lvl = f[b];
      if (glitch && (c % CLK_DIV) == 7 + ((c / CLK_DIV) % 3)) lvl = ~lvl;
      set_rx(sel, lvl);
    end
    if (cut == 0) begin
      @(negedge sclk);
      set_rx(sel, 1'b1);
      repeat (6) @(negedge sclk);
    end
  endtask

  task automatic check_rx(input string tag, input bit sel, input int n_before, input logic [8:0] pay,
                          input bit flip, input logic [1:0] stops);
    int par, sb;
    logic ep, ef, eb, allz;
    par = sel ? 2 : 0; sb = sel ? 2 : 1;
    ep = (par != 0) && flip;
    ef = 1'b0; allz = 1'b1;
    for (int i = 0; i < sb; i++) begin
      if (!stops[i]) ef = 1'b1;
      else allz = 1'b0;
    end
    eb = (pay == 0) && (par == 0 || pbit_of(pay, par, flip) == 1'b0) && allz;
    chk({tag, "_cnt"},  sel ? n7 : n8, n_before + 1);
    chk({tag, "_data"}, sel ? d7 : d8, {23'd0, pay});
    chk({tag, "_perr"}, {31'd0, sel ? p7 : p8}, {31'd0, ep});
    chk({tag, "_ferr"}, {31'd0, sel ? f7 : f8}, {31'd0, ef});
    chk({tag, "_brk"},  {31'd0, sel ? b7 : b8}, {31'd0, eb});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data8"}, {24'd0, if8.po_data}, 32'd0);
    chk({tag, "_data7"}, {25'd0, if7.po_data}, 32'd0);
    chk({tag, "_ctl8"}, {28'd0, if8.po_flag, if8.po_perr, if8.po_ferr, if8.po_brk}, 32'd0);
    chk({tag, "_ctl7"}, {28'd0, if7.po_flag, if7.po_perr, if7.po_ferr, if7.po_brk}, 32'd0);
  endtask

  initial begin
    int n0, t0;
    logic [8:0] p;
    bit fl, sel;
    logic [1:0] st;
    int per;

    if8.rx = 1'b1; if7.rx = 1'b1; rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge sclk);

    // 8N1 0xA5 with latency measured from the start edge
    n0 = n8;
    send(0, 9'hA5, 0, 2'b11, 1600, 0, 0, t0);
    check_rx("t1", 0, n0, 9'hA5, 0, 2'b11);
    chk("t1_latency", t8 - t0, 2 + 16 * 9 + 9);

    // 7E2: correct parity, then corrupted parity
    n0 = n7;
    send(1, 9'h35, 0, 2'b11, 1600, 0, 0, t0);
    check_rx("t2a", 1, n0, 9'h35, 0, 2'b11);
    chk("t2_latency", t7 - t0, 2 + 16 * 10 + 9);
    n0 = n7;
    send(1, 9'h35, 1, 2'b11, 1600, 0, 0, t0);
    check_rx("t2b", 1, n0, 9'h35, 1, 2'b11);

    // Short low pulse must be rejected as a start bit
    n0 = n8;
    @(negedge sclk); if8.rx = 1'b0;
    repeat (6) @(negedge sclk); if8.rx = 1'b1;
    repeat (40) @(negedge sclk);
    chk("t3_no_pulse", n8, n0);
    send(0, 9'h3C, 0, 2'b11, 1600, 0, 0, t0);
    check_rx("t3", 0, n0, 9'h3C, 0, 2'b11);

    // Stop bit low, then a long break
    n0 = n8;
    send(0, 9'h055, 0, 2'b10, 1600, 0, 0, t0);
    check_rx("t4a", 0, n0, 9'h055, 0, 2'b10);
    n0 = n8;
    @(negedge sclk); if8.rx = 1'b0;
    repeat (40 * CLK_DIV) @(negedge sclk);
    check_rx("t4b", 0, n0, 9'h000, 0, 2'b00);
    if8.rx = 1'b1;
    repeat (40) @(negedge sclk);
    chk("t4_one_pulse", n8, n0 + 1);
    n0 = n8;
    send(0, 9'h0C3, 0, 2'b11, 1600, 0, 0, t0);
    check_rx("t4c", 0, n0, 9'h0C3, 0, 2'b11);

    // Glitches on sample points, then baud skew of +/-3%
    n0 = n8;
    send(0, 9'h0FF, 0, 2'b11, 1600, 1, 0, t0);
    check_rx("t5_glitch", 0, n0, 9'h0FF, 0, 2'b11);
    n0 = n8;
    send(0, 9'h0FF, 0, 2'b11, 1648, 0, 0, t0);
    check_rx("t5_slow", 0, n0, 9'h0FF, 0, 2'b11);
    n0 = n8;
    send(0, 9'h0FF, 0, 2'b11, 1552, 0, 0, t0);
    check_rx("t5_fast", 0, n0, 9'h0FF, 0, 2'b11);
    n0 = n7;
    send(1, 9'h035, 0, 2'b11, 1600, 1, 0, t0);
    check_rx("t5_glitch7", 1, n0, 9'h035, 0, 2'b11);

    // Reset in the middle of a frame abandons it
    n0 = n8;
    send(0, 9'h081, 0, 2'b11, 1600, 0, 60, t0);
    rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    check_reset_outputs("t6_in_reset");
    if8.rx = 1'b1;
    repeat (4) @(negedge sclk);
    rst_n = 1'b1;
    repeat (200) @(negedge sclk);
    chk("t6_no_pulse", n8, n0);
    send(0, 9'h018, 0, 2'b11, 1600, 0, 0, t0);
    check_rx("t6", 0, n0, 9'h018, 0, 2'b11);

    // Randomised frames on both instances with skew and occasional bad stop/parity
    for (int i = 0; i < 12; i++) begin
      sel = i[0];
      p   = sel ? 9'($urandom_range(0, 127)) : 9'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) p = '0;
      fl  = sel ? bit'($urandom_range(0, 1)) : 1'b0;
      st  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      per = 1552 + $urandom_range(0, 96);
      n0  = sel ? n7 : n8;
      send(sel, p, fl, st, per, 0, 0, t0);
      check_rx($sformatf("rnd%0d", i), sel, n0, p, fl, st);
      repeat (20) @(negedge sclk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
